iteration_sequencer_mvp: RTL
============================

# iteration_sequencer_mvp

Control FSM that sequences the div/sqrt iteration datapath in the FPU mantissa path. It accepts one operation at a time over a valid/ready handshake and latches the operation type and iteration count. It then drives the datapath enables and first-iteration strobe for exactly N cycles, and presents completion over a second valid/ready handshake. It owns no arithmetic: operand, remainder and quotient registers live in the datapath and are qualified by this block's strobes.

## Interface
- WIDTH, 25: mantissa iteration width; default and maximum iteration count.
- CNT_W, $clog2(WIDTH+1): width of iteration-count fields.

- Clk_CI  in  1  clock; all state updates on its rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- In_valid_SI  in  1  operation request.
- In_ready_SO  out  1  request accepted when high together with In_valid_SI.
- Op_div_SI  in  1  1 = divide, 0 = square root; sampled on accept.
- Iter_num_SI  in  CNT_W  requested iteration count; sampled on accept.
- Kill_SI  in  1  synchronous abort of any operation.
- Load_SO  out  1  datapath operand-load strobe; equals accept.
- Div_enable_SO  out  1  divide iteration active.
- Sqrt_enable_SO  out  1  sqrt iteration active.
- Div_start_dly_SO  out  1  first iteration cycle of the current operation.
- Last_iter_SO  out  1  final iteration cycle.
- Iter_cnt_DO  out  CNT_W  index of the current iteration, 0..N-1.
- Busy_SO  out  1  state is not IDLE.
- Out_valid_SO  out  1  result in datapath is complete.
- Out_ready_SI  in  1  consumer takes the result.
- Out_op_div_SO  out  1  latched Op_div for the completed result.

## Operation
- States: IDLE, ITER, DONE. Reset enters IDLE.
- Iteration count: N = WIDTH if Iter_num_SI == 0 or Iter_num_SI > WIDTH; otherwise N = Iter_num_SI. N is latched on accept.
- Ready: In_ready_SO = ~Kill_SI & (IDLE | (DONE & Out_ready_SI)).
- Accept: accept = In_valid_SI & In_ready_SO. Load_SO = accept, combinational.
- On accept: latch op and N, clear the counter, next state ITER.
- ITER:
  - Div_enable_SO = op_div and Sqrt_enable_SO = ~op_div, both held for all N cycles.
  - Div_start_dly_SO = (cnt == 0).
  - Last_iter_SO = (cnt == N-1).
  - Counter increments each cycle. When Last_iter_SO is high, next state is DONE.
- DONE:
  - Out_valid_SO = 1 until Out_ready_SI.
  - On Out_ready_SI with no accept, next state is IDLE.
  - On Out_ready_SI with a same-cycle accept, next state is ITER with the new op (back-to-back).
- Outside ITER: Div_enable_SO, Sqrt_enable_SO, Div_start_dly_SO and Last_iter_SO are all 0.
- Kill_SI:
  - Highest priority. Next state is IDLE, the counter clears, and Out_valid_SO drops next cycle.
  - In the cycle where Kill_SI is high, In_ready_SO = 0, so no accept occurs.
- N = 1: Div_start_dly_SO and Last_iter_SO are both high in the single ITER cycle.
- Iter_cnt_DO is held at its last value in DONE and is 0 in IDLE.
- Out_op_div_SO holds the latched op from accept until the next accept.

## Timing
- Accept occurs in cycle t. ITER covers cycles t+1..t+N. Out_valid_SO rises in cycle t+N+1.
- Minimum accept-to-accept spacing: N+1 cycles (back-to-back through DONE).
- Registered outputs: state, counter, latched op/N, Out_valid_SO.
- Combinational outputs: In_ready_SO and Load_SO, from state, Kill_SI and Out_ready_SI.
- Reset values:
  - state IDLE, counter 0, latched N = WIDTH, latched op 0.
  - Out_valid_SO, Busy_SO, all enables, Div_start_dly_SO, Last_iter_SO and Out_op_div_SO are 0.
  - In_ready_SO = ~Kill_SI.
- Reset mid-operation: asynchronous return to IDLE. No Out_valid_SO for the aborted operation.
- In_valid_SI with In_ready_SO low: no state change. The requester holds its fields stable until accepted.

## Test plan
- Divide, Iter_num_SI = 0, WIDTH = 25:
  - Div_enable_SO high for exactly 25 cycles; Div_start_dly_SO only at Iter_cnt_DO = 0; Last_iter_SO only at 24.
  - Out_valid_SO in cycle t+26; Out_op_div_SO = 1.
- Sqrt, Iter_num_SI = 12:
  - Sqrt_enable_SO high for 12 cycles; Div_enable_SO stays 0.
  - Out_valid_SO held 3 cycles with Out_ready_SI low, then releases to IDLE.
- Clamp and single-iteration cases:
  - Iter_num_SI = 30 runs 25 iterations.
  - Iter_num_SI = 1 gives one ITER cycle with Div_start_dly_SO = Last_iter_SO = 1.
- Back-to-back: in DONE, assert Out_ready_SI and In_valid_SI (sqrt, 4).
  - Load_SO is high that cycle and the next cycle is ITER with Sqrt_enable_SO = 1; no IDLE cycle in between.
- Kill at Iter_cnt_DO = 7 of a divide:
  - Next cycle IDLE, all enables 0, no Out_valid_SO.
  - Kill_SI together with In_valid_SI in IDLE gives In_ready_SO = 0 and Load_SO = 0.
- Rst_RBI low at Iter_cnt_DO = 10:
  - All outputs go to reset values immediately, asynchronously.
  - After release, a new divide completes normally in N+1 cycles.

Source files
------------

// File: rtl/iteration_sequencer_mvp.sv
// Control FSM for the div/sqrt mantissa iteration datapath: accepts one op,
// strobes the datapath for N iterations, then holds the result until it is consumed.
module iteration_sequencer_mvp #(
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             In_valid_SI,
  output logic             In_ready_SO,
  input  logic             Op_div_SI,
  input  logic [CNT_W-1:0] Iter_num_SI,
  input  logic             Kill_SI,
  output logic             Load_SO,
  output logic             Div_enable_SO,
  output logic             Sqrt_enable_SO,
  output logic             Div_start_dly_SO,
  output logic             Last_iter_SO,
  output logic [CNT_W-1:0] Iter_cnt_DO,
  output logic             Busy_SO,
  output logic             Out_valid_SO,
  input  logic             Out_ready_SI,
  output logic             Out_op_div_SO
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic             op_reg, op_next;
  logic [CNT_W-1:0] n_in;
  logic             accept;
  logic             last;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      n_reg     <= MAX_N;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    // Zero or out-of-range requests run the full mantissa width
    n_in        = ((Iter_num_SI == '0) || (Iter_num_SI > MAX_N)) ? MAX_N : Iter_num_SI;
    In_ready_SO = ~Kill_SI & ((state_reg == IDLE) | ((state_reg == DONE) & Out_ready_SI));
    accept      = In_valid_SI & In_ready_SO;
    last        = (state_reg == ITER) && (cnt_reg == (n_reg - CNT_W'(1)));

    state_next = state_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    op_next    = op_reg;

    if (Kill_SI) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_next = ITER;
            cnt_next   = '0;
            n_next     = n_in;
            op_next    = Op_div_SI;
          end
        end
        ITER: begin
          // Counter stays on its final index through DONE
          if (last) state_next = DONE;
          else      cnt_next   = cnt_reg + CNT_W'(1);
        end
        DONE: begin
          if (accept) begin
            state_next = ITER;
            cnt_next   = '0;
            n_next     = n_in;
            op_next    = Op_div_SI;
          end else if (Out_ready_SI) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign Load_SO          = accept;
  assign Div_enable_SO    = (state_reg == ITER) & op_reg;
  assign Sqrt_enable_SO   = (state_reg == ITER) & ~op_reg;
  assign Div_start_dly_SO = (state_reg == ITER) & (cnt_reg == '0);
  assign Last_iter_SO     = last;
  assign Iter_cnt_DO      = cnt_reg;
  assign Busy_SO          = (state_reg != IDLE);
  assign Out_valid_SO     = (state_reg == DONE);
  assign Out_op_div_SO    = op_reg;

endmodule
